elevator_ctrl: RTL and testbench

Parametrised N-floor elevator controller: the successor to the single-input red/green elevator FSM. It latches per-floor call requests and moves a car floor by floor using SCAN (keep direction while work remains ahead). It holds the door open for a programmable time at each served floor. The red/green indicator pair is retained for the existing lamp drivers. It sits between the call-button synchroniser bank and the motor/door/lamp drivers.

---
 rtl/elevator_if.sv | 35 +++
 rtl/elevator_ctrl.sv | 149 ++++++++++++++
 tb/tb_elevator_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/elevator_if.sv
// Call/status bundle between the call-button synchroniser bank and elevator_ctrl.
// ELEV_HOLD_EN adds the door hold input.
interface elevator_if #(
  parameter int FLOORS = 8
);
  localparam int FW = $clog2(FLOORS);

  logic [FLOORS-1:0] call;
`ifdef ELEV_HOLD_EN
  logic              hold;
`endif
  logic [FW-1:0]     floor;
  logic              dir_up;
  logic              moving;
  logic              door_open;
  logic              red;
  logic              green;
  logic [FLOORS-1:0] pending;

`ifdef ELEV_HOLD_EN
  modport master (output call, output hold,
                  input floor, input dir_up, input moving, input door_open,
                  input red, input green, input pending);
  modport slave  (input call, input hold,
                  output floor, output dir_up, output moving, output door_open,
                  output red, output green, output pending);
`else
  modport master (output call,
                  input floor, input dir_up, input moving, input door_open,
                  input red, input green, input pending);
  modport slave  (input call,
                  output floor, output dir_up, output moving, output door_open,
                  output red, output green, output pending);
`endif
endinterface

// File: rtl/elevator_ctrl.sv
// N-floor SCAN elevator controller with latched calls and timed door service.
// Optional feature macro: ELEV_HOLD_EN (door hold input on the interface).
module elevator_ctrl #(
  parameter int FLOORS = 8,
  parameter int TRAVEL = 4,
  parameter int DOOR   = 3
) (
  input logic       clk,
  input logic       reset,
  elevator_if.slave bus
);
  localparam int FW   = $clog2(FLOORS);
  localparam int TMAX = (TRAVEL > DOOR) ? TRAVEL : DOOR;
  localparam int TW   = ($clog2(TMAX + 1) > 4) ? $clog2(TMAX + 1) : 4;
  localparam logic [TW-1:0] T_TRAVEL = TW'(TRAVEL);
  localparam logic [TW-1:0] T_DOOR   = TW'(DOOR);
  localparam logic [TW-1:0] T_ONE    = TW'(1);

  typedef enum logic [1:0] {S_IDLE, S_MOVE, S_DOOR} state_t;

  state_t            state_reg;
  logic [FW-1:0]     floor_reg;
  logic              dir_up_reg;
  logic [FLOORS-1:0] pending_reg;
  logic [TW-1:0]     timer_reg;
  logic              moving_reg;
  logic              door_open_reg;

  logic [FW-1:0]     step_floor;
  logic [FLOORS-1:0] above_cur, below_cur, above_step, below_step;
  logic [FLOORS-1:0] call_eff, clear;
  logic              ahead_cur, behind_cur, ahead_step;
  logic              arrive, reload;

  // Per-floor masks of floors strictly above/below the current and the next floor.
  generate
    for (genvar gi = 0; gi < FLOORS; gi++) begin : g_mask
      assign above_cur[gi]  = gi > int'(floor_reg);
      assign below_cur[gi]  = gi < int'(floor_reg);
      assign above_step[gi] = gi > int'(step_floor);
      assign below_step[gi] = gi < int'(step_floor);
    end
  endgenerate

  assign step_floor = dir_up_reg ? floor_reg + FW'(1) : floor_reg - FW'(1);
  assign ahead_cur  = dir_up_reg ? |(pending_reg & above_cur) : |(pending_reg & below_cur);
  assign behind_cur = dir_up_reg ? |(pending_reg & below_cur) : |(pending_reg & above_cur);
  assign ahead_step = dir_up_reg ? |(pending_reg & above_step) : |(pending_reg & below_step);
  assign arrive     = (state_reg == S_MOVE) && (timer_reg == T_ONE);

`ifdef ELEV_HOLD_EN
  assign reload = bus.call[floor_reg] | bus.hold;
`else
  assign reload = bus.call[floor_reg];
`endif

  // The served floor's bit is cleared on the serving edge, overriding a same-edge call;
  // a call to the open floor only extends the door and is never latched.
  always_comb begin
    call_eff = bus.call;
    clear    = '0;
    case (state_reg)
      S_IDLE:  if (pending_reg[floor_reg]) clear = FLOORS'(1) << floor_reg;
      S_MOVE:  if (arrive && pending_reg[step_floor]) clear = FLOORS'(1) << step_floor;
      S_DOOR:  call_eff[floor_reg] = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg     <= S_IDLE;
      floor_reg     <= '0;
      dir_up_reg    <= 1'b1;
      pending_reg   <= '0;
      timer_reg     <= '0;
      moving_reg    <= 1'b0;
      door_open_reg <= 1'b0;
    end else begin
      pending_reg <= (pending_reg | call_eff) & ~clear;
      case (state_reg)
        S_IDLE: begin
          if (pending_reg[floor_reg]) begin
            state_reg     <= S_DOOR;
            timer_reg     <= T_DOOR;
            door_open_reg <= 1'b1;
          end else if (ahead_cur) begin
            state_reg  <= S_MOVE;
            timer_reg  <= T_TRAVEL;
            moving_reg <= 1'b1;
          end else if (behind_cur) begin
            dir_up_reg <= ~dir_up_reg;
            state_reg  <= S_MOVE;
            timer_reg  <= T_TRAVEL;
            moving_reg <= 1'b1;
          end
        end
        S_MOVE: begin
          if (arrive) begin
            floor_reg <= step_floor;
            if (pending_reg[step_floor]) begin
              state_reg     <= S_DOOR;
              timer_reg     <= T_DOOR;
              moving_reg    <= 1'b0;
              door_open_reg <= 1'b1;
            end else if (ahead_step) begin
              timer_reg <= T_TRAVEL;
            end else begin
              state_reg  <= S_IDLE;
              timer_reg  <= '0;
              moving_reg <= 1'b0;
            end
          end else begin
            timer_reg <= timer_reg - T_ONE;
          end
        end
        S_DOOR: begin
          if (reload) begin
            timer_reg <= T_DOOR;
          end else if (timer_reg == T_ONE) begin
            state_reg     <= S_IDLE;
            timer_reg     <= '0;
            door_open_reg <= 1'b0;
          end else begin
            timer_reg <= timer_reg - T_ONE;
          end
        end
        default: begin
          state_reg     <= S_IDLE;
          timer_reg     <= '0;
          moving_reg    <= 1'b0;
          door_open_reg <= 1'b0;
        end
      endcase
    end
  end

  // An arrival step must never leave the shaft.
  assert property (@(posedge clk) disable iff (!reset)
    arrive |-> (dir_up_reg ? (int'(floor_reg) < FLOORS - 1) : (floor_reg != '0)));

  assign bus.floor     = floor_reg;
  assign bus.dir_up    = dir_up_reg;
  assign bus.moving    = moving_reg;
  assign bus.door_open = door_open_reg;
  assign bus.red       = ~door_open_reg;
  assign bus.green     = door_open_reg;
  assign bus.pending   = pending_reg;
endmodule

// File: tb/tb_elevator_ctrl.sv
// Bench for elevator_ctrl: directed scenarios plus random calls, checked by a
// procedural SCAN model feeding door-open/close expectations to a monitor.
module tb_elevator_ctrl;
  localparam int FLOORS = 4;
  localparam int TRAVEL = 4;
  localparam int DOOR   = 3;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   started = 0;

  elevator_if #(.FLOORS(FLOORS)) bus ();

  elevator_ctrl #(.FLOORS(FLOORS), .TRAVEL(TRAVEL), .DOOR(DOOR)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { int fl; int t; } ev_t;
  ev_t open_q[$];
  int  close_q[$];
  bit  req[FLOORS];
  int  here;
  bit  up;
  bit  abort;
  int  et;

  function automatic bit work(input bit dirup, input int fl);
    for (int f = 0; f < FLOORS; f++)
      if (req[f] && (dirup ? (f > fl) : (f < fl))) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [FLOORS-1:0] model_pending();
    logic [FLOORS-1:0] v;
    for (int f = 0; f < FLOORS; f++) v[f] = req[f];
    return v;
  endfunction

  // One clock edge: latch calls, apply a clear, report a door-extending request.
  task automatic edge_(input int clr, input bit door, output bit ext);
    logic [FLOORS-1:0] c;
    @(posedge clk);
    et  = cyc;
    c   = bus.call;
    ext = 1'b0;
    if (!rst_n) begin
      abort = 1'b1;
      return;
    end
    for (int f = 0; f < FLOORS; f++) begin
      if (door && f == here) ext = c[f];
      else if (c[f]) req[f] = 1'b1;
    end
    if (clr >= 0) req[clr] = 1'b0;
`ifdef ELEV_HOLD_EN
    if (door && bus.hold) ext = 1'b1;
`endif
  endtask

  task automatic door_seq();
    int rem = DOOR;
    bit ext;
    open_q.push_back('{here, et});
    while (rem > 0) begin
      edge_(-1, 1'b1, ext);
      if (abort) break;
      rem = ext ? DOOR : rem - 1;
    end
    close_q.push_back(et);
  endtask

  task automatic travel();
    bit ext, go, more;
    int nf;
    go = 1'b1;
    edge_(-1, 1'b0, ext);
    if (abort) return;
    while (go) begin
      repeat (TRAVEL - 1) begin
        edge_(-1, 1'b0, ext);
        if (abort) return;
      end
      nf = up ? here + 1 : here - 1;
      if (req[nf]) begin
        edge_(nf, 1'b0, ext);
        if (abort) return;
        here = nf;
        door_seq();
        go = 1'b0;
      end else begin
        more = work(up, nf);
        edge_(-1, 1'b0, ext);
        if (abort) return;
        here = nf;
        go = more;
      end
    end
  endtask

  task automatic run_model();
    bit ext;
    while (!abort) begin
      if (req[here]) begin
        edge_(here, 1'b0, ext);
        if (!abort) door_seq();
      end else if (work(up, here)) begin
        travel();
      end else if (work(!up, here)) begin
        up = !up;
        travel();
      end else begin
        edge_(-1, 1'b0, ext);
      end
    end
  endtask

  initial begin
    forever begin
      abort = 1'b0;
      here  = 0;
      up    = 1'b1;
      for (int f = 0; f < FLOORS; f++) req[f] = 1'b0;
      run_model();
    end
  end

  // ---------------- monitor ----------------
  bit  prev_door = 1'b0;
  ev_t mev;
  int  mclose;
  always @(negedge clk) begin
    if (started) begin
      chk("red_vs_door", bus.red, !bus.door_open);
      chk("green_vs_door", bus.green, bus.door_open);
      if (bus.door_open && !prev_door) begin
        if (open_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL door_open: opened at floor %0d edge %0d, expected no service", bus.floor, cyc - 1);
        end else begin
          mev = open_q.pop_front();
          $display("service open floor %0d edge %0d", bus.floor, cyc - 1);
          chk("open_floor", bus.floor, mev.fl);
          chk("open_edge", cyc - 1, mev.t);
        end
      end
      if (!bus.door_open && prev_door) begin
        if (close_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL door_close: closed at edge %0d, expected no close", cyc - 1);
        end else begin
          mclose = close_q.pop_front();
          chk("close_edge", cyc - 1, mclose);
        end
      end
    end
    prev_door = bus.door_open;
  end

  // ---------------- stimulus ----------------
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [FLOORS-1:0] rand_call();
    logic [FLOORS-1:0] c = '0;
    int r = $urandom_range(0, 9);
    if (r < 3) c[$urandom_range(0, FLOORS - 1)] = 1'b1;
    if (r == 0) c[$urandom_range(0, FLOORS - 1)] = 1'b1;
    return c;
  endfunction

  task automatic wait_idle(input int budget);
    int n = 0;
    while (n < budget && !(bus.moving == 1'b0 && bus.door_open == 1'b0 && bus.pending == '0)) begin
      step(1);
      n++;
    end
    chk("drain_in_budget", n < budget, 1);
    chk("floor_vs_model", bus.floor, here);
    chk("pending_vs_model", bus.pending, model_pending());
    chk("dir_vs_model", bus.dir_up, up);
  endtask

  task automatic random_phase(input int n);
    for (int i = 0; i < n; i++) begin
      bus.call = rand_call();
      step(1);
    end
    bus.call = '0;
    wait_idle(400);
  endtask

  initial begin
    int start;
    rst_n    = 1'b0;
    bus.call = '0;
`ifdef ELEV_HOLD_EN
    bus.hold = 1'b0;
`endif
    step(2);
    started = 1;
    chk("rst_floor", bus.floor, 0);
    chk("rst_dir_up", bus.dir_up, 1);
    chk("rst_red", bus.red, 1);
    chk("rst_green", bus.green, 0);
    chk("rst_pending", bus.pending, 0);
    chk("rst_moving", bus.moving, 0);

    // Single call to floor 2 from idle at floor 0.
    rst_n = 1'b1;
    bus.call = 4'b0100;
    step(1); bus.call = '0;
    chk("s2_pending_e1", bus.pending, 4'b0100);
    step(1); chk("s2_moving_e2", bus.moving, 1);
    step(4); chk("s2_floor_e6", bus.floor, 1);
    step(4); chk("s2_floor_e10", bus.floor, 2);
    chk("s2_green_e10", bus.green, 1);
    step(2); chk("s2_green_e12", bus.green, 1);
    step(1); chk("s2_red_e13", bus.red, 1);

    // Calls above and below at once: SCAN keeps going up first.
    bus.call = 4'b1001;
    step(1); bus.call = '0;
    step(1); chk("s3_dir_kept", bus.dir_up, 1);
    wait_idle(200);
    chk("s3_end_floor", bus.floor, 0);
    chk("s3_end_dir", bus.dir_up, 0);

    // En-route stop at floor 1 called two cycles before passing it.
    bus.call = 4'b1000;
    step(1); bus.call = '0;
    step(2); bus.call = 4'b0010;
    step(1); bus.call = '0;
    step(2);
    chk("s4_stop_floor", bus.floor, 1);
    chk("s4_stop_door", bus.door_open, 1);
    wait_idle(200);
    chk("s4_end_floor", bus.floor, 3);

`ifdef ELEV_HOLD_EN
    bus.call = 4'b1000;
    step(1); bus.call = '0; bus.hold = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(1);
      chk("hold_door_open", bus.door_open, 1);
    end
    bus.hold = 1'b0;
    step(2); chk("hold_tail_open", bus.door_open, 1);
    step(1); chk("hold_tail_closed", bus.door_open, 0);
    wait_idle(200);
`endif

    random_phase(1500);

    // Reset in the middle of a move abandons everything.
    start = here;
    bus.call = (start == FLOORS - 1) ? 4'b0001 : 4'b1000;
    step(1); bus.call = rand_call();
    step(6); bus.call = '0;
    chk("pre_reset_moving", bus.moving, 1);
    chk("pre_reset_floor", bus.floor, (start == FLOORS - 1) ? start - 1 : start + 1);
    rst_n = 1'b0;
    step(1); rst_n = 1'b1;
    chk("mid_rst_floor", bus.floor, 0);
    chk("mid_rst_pending", bus.pending, 0);
    chk("mid_rst_moving", bus.moving, 0);
    chk("mid_rst_door", bus.door_open, 0);

    random_phase(1000);
    step(2);
    chk("open_q_empty", open_q.size(), 0);
    chk("close_q_empty", close_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
